// File: rtl/crc_unit_pkg.sv
// Shared types and Modbus defaults for the parametrised CRC engine.
package crc_unit_pkg;

  typedef enum logic [0:0] {
    CRC_IDLE_S  = 1'b0,
    CRC_SHIFT_S = 1'b1
  } crc_state_t;

  localparam logic [15:0] MODBUS_POLY = 16'hA001;
  localparam logic [15:0] MODBUS_INIT = 16'hFFFF;

  // Shift counter width; a single-cycle fold still needs one bit.
  function automatic int crc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC fold: applies BITS_PER_CLK LFSR steps to the register.
module crc_step #(
  parameter int               CRC_W        = 16,
  parameter logic [CRC_W-1:0] POLY         = '0,
  parameter bit               REFLECT      = 1'b1,
  parameter int               BITS_PER_CLK = 1
) (
  input  logic [CRC_W-1:0] crc_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] r;

  always_comb begin
    r = crc_i;
    for (int k = 0; k < BITS_PER_CLK; k++) begin
      if (REFLECT) r = (r >> 1) ^ (r[0] ? POLY : '0);
      else         r = (r << 1) ^ (r[CRC_W-1] ? POLY : '0);
    end
    crc_o = r;
  end

endmodule

// File: rtl/crc_unit.sv
// Handshaked CRC engine: one word accepted in IDLE, folded over DATA_W/BITS_PER_CLK cycles.
module crc_unit
  import crc_unit_pkg::*;
#(
  parameter int               CRC_W        = 16,
  parameter logic [CRC_W-1:0] POLY         = CRC_W'(MODBUS_POLY),
  parameter logic [CRC_W-1:0] INIT         = CRC_W'(MODBUS_INIT),
  parameter logic [CRC_W-1:0] XOROUT       = '0,
  parameter bit               REFLECT      = 1'b1,
  parameter int               DATA_W       = 8,
  parameter int               BITS_PER_CLK = 1,
  parameter logic [CRC_W-1:0] RESIDUE      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vi,
  output logic              ready,
  input  logic [DATA_W-1:0] di,
  input  logic              last,
  output logic [CRC_W-1:0]  crc,
  output logic              done,
  output logic              match,
  output logic              busy
);

  localparam int N     = DATA_W / BITS_PER_CLK;
  localparam int CNT_W = crc_cnt_w(N);

  if (DATA_W % BITS_PER_CLK != 0) begin : g_chk_div
    $fatal(1, "crc_unit: BITS_PER_CLK must divide DATA_W");
  end
  if (!REFLECT && CRC_W < DATA_W) begin : g_chk_w
    $fatal(1, "crc_unit: MSB-first mode needs CRC_W >= DATA_W");
  end

  crc_state_t       state_q, state_d;
  logic [CRC_W-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic [CRC_W-1:0] di_ext;
  logic [CRC_W-1:0] step_o;

  // MSB-first aligns the word with the top of the register.
  if (REFLECT) begin : g_ext_r
    assign di_ext = CRC_W'(di);
  end else begin : g_ext_n
    assign di_ext = CRC_W'(di) << (CRC_W - DATA_W);
  end

  crc_step #(
    .CRC_W       (CRC_W),
    .POLY        (POLY),
    .REFLECT     (REFLECT),
    .BITS_PER_CLK(BITS_PER_CLK)
  ) u_step (
    .crc_i(reg_q),
    .crc_o(step_o)
  );

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    match_d = match_q;
    case (state_q)
      CRC_IDLE_S: begin
        if (start) begin
          reg_d   = INIT;
          match_d = 1'b0;
        end
        if (vi) begin
          reg_d   = (start ? INIT : reg_q) ^ di_ext;
          last_d  = last;
          cnt_d   = '0;
          state_d = CRC_SHIFT_S;
        end
      end
      CRC_SHIFT_S: begin
        // start aborts the word in flight; vi is not sampled here.
        if (start) begin
          reg_d   = INIT;
          match_d = 1'b0;
          cnt_d   = '0;
          state_d = CRC_IDLE_S;
        end else begin
          reg_d = step_o;
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = CRC_IDLE_S;
            if (last_q) match_d = (step_o == RESIDUE);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = CRC_IDLE_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CRC_IDLE_S;
      reg_q   <= INIT;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign ready = (state_q == CRC_IDLE_S);
  assign busy  = (state_q == CRC_SHIFT_S);
  assign crc   = reg_q ^ XOROUT;
  assign done  = done_q;
  assign match = match_q;

endmodule

// File: tb/tb_crc_unit.sv
// Scoreboard bench for crc_unit: four configurations driven by directed byte vectors.
module tb_crc_unit;

  typedef struct {
    int          cyc;
    bit          chk_crc;
    logic [31:0] crc;
    bit          chk_m;
    logic        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        vi [4];
  logic        start [4];
  logic        last [4];
  logic [7:0]  di [4];
  logic        rdy [4];
  logic        bsy [4];
  logic        dn [4];
  logic        mt [4];
  logic [31:0] crcw [4];
  logic [15:0] crc0, crc1, crc3;
  logic [31:0] crc2;

  exp_t        q [4][$];
  int          nfold [4]   = '{8, 1, 8, 8};
  logic [31:0] rst_crc [4] = '{32'hFFFF, 32'hFFFF, 32'h0, 32'hFFFF};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign crcw[0] = 32'(crc0);
  assign crcw[1] = 32'(crc1);
  assign crcw[2] = crc2;
  assign crcw[3] = 32'(crc3);

  crc_unit u0 (
    .clk(clk), .rst(rst), .start(start[0]), .vi(vi[0]), .ready(rdy[0]), .di(di[0]),
    .last(last[0]), .crc(crc0), .done(dn[0]), .match(mt[0]), .busy(bsy[0]));

  crc_unit #(.BITS_PER_CLK(8)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .vi(vi[1]), .ready(rdy[1]), .di(di[1]),
    .last(last[1]), .crc(crc1), .done(dn[1]), .match(mt[1]), .busy(bsy[1]));

  crc_unit #(.CRC_W(32), .POLY(32'hEDB88320), .INIT(32'hFFFFFFFF),
             .XOROUT(32'hFFFFFFFF), .RESIDUE(32'h0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .vi(vi[2]), .ready(rdy[2]), .di(di[2]),
    .last(last[2]), .crc(crc2), .done(dn[2]), .match(mt[2]), .busy(bsy[2]));

  crc_unit #(.REFLECT(1'b0), .POLY(16'h1021), .INIT(16'hFFFF)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .vi(vi[3]), .ready(rdy[3]), .di(di[3]),
    .last(last[3]), .crc(crc3), .done(dn[3]), .match(mt[3]), .busy(bsy[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  function automatic exp_t mk(input bit cc, input logic [31:0] c, input bit cm, input logic m);
    exp_t e;
    e.cyc = 0; e.chk_crc = cc; e.crc = c; e.chk_m = cm; e.m = m;
    return e;
  endfunction

  // Monitor: every done pops one expectation and checks latency, crc and match.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (dn[k] === 1'b1) begin
        if (q[k].size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL dut%0d unexpected done: crc %h, want no done", k, crcw[k]);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("dut%0d done cycle", k), 32'(cyc), 32'(e.cyc));
          if (e.chk_crc) chk($sformatf("dut%0d crc", k), crcw[k], e.crc);
          if (e.chk_m)   chk($sformatf("dut%0d match", k), 32'(mt[k]), 32'(e.m));
        end
      end
    end
  end

  // Waits for ready, presents one word, and queues its expectation at the accept edge.
  task automatic send(input int k, input logic [7:0] d, input logic l, input logic s,
                      input bit hold, input bit push, input exp_t e, output int acc);
    int t;
    t = 0;
    acc = 0;
    @(negedge clk);
    while (rdy[k] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (rdy[k] !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL dut%0d ready timeout: ready %b, want 1", k, rdy[k]);
      return;
    end
    vi[k] = 1'b1; di[k] = d; last[k] = l; start[k] = s;
    @(posedge clk); #1;
    acc = cyc;
    e.cyc = cyc + nfold[k];
    if (push) q[k].push_back(e);
    start[k] = 1'b0;
    if (!hold) begin vi[k] = 1'b0; last[k] = 1'b0; end
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (q[k].size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (q[k].size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL dut%0d done timeout: %0d pending, want 0", k, q[k].size());
      q[k].delete();
    end
    @(negedge clk);
  endtask

  task automatic frame9(input int k, input logic [31:0] fin, input bit hold, input int per);
    logic [7:0] b;
    int a, pa;
    pa = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'h31 + 8'(i);
      send(k, b, i == 8, i == 0, hold && i < 8, 1'b1, mk(i == 8, fin, i == 8, 1'b0), a);
      if (hold && i > 0) chk($sformatf("dut%0d accept period", k), 32'(a - pa), 32'(per));
      pa = a;
    end
    drain(k);
  endtask

  task automatic modbus(input logic [7:0] fc, input bit good);
    logic [7:0] mb [8];
    int a;
    mb = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    mb[1] = fc;
    for (int i = 0; i < 8; i++)
      send(0, mb[i], i == 7, i == 0, 1'b0, 1'b1,
           mk(good && (i == 5 || i == 7), (i == 5) ? 32'h0A84 : 32'h0, i == 7, good), a);
    drain(0);
  endtask

  initial begin : stim
    int a;
    for (int k = 0; k < 4; k++) begin
      vi[k] = 1'b0; start[k] = 1'b0; last[k] = 1'b0; di[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dut%0d reset crc", k), crcw[k], rst_crc[k]);
      chk($sformatf("dut%0d reset ready", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("dut%0d reset busy", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("dut%0d reset match", k), 32'(mt[k]), 32'd0);
    end

    frame9(0, 32'h4B37, 1'b1, 9);
    frame9(1, 32'h4B37, 1'b1, 2);
    frame9(2, 32'hCBF43926, 1'b0, 0);
    frame9(3, 32'h29B1, 1'b0, 0);

    // Good Modbus frame leaves a zero residue; match holds until start.
    modbus(8'h03, 1'b1);
    chk("match held", 32'(mt[0]), 32'd1);
    start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    @(negedge clk);
    chk("match cleared by start", 32'(mt[0]), 32'd0);
    chk("crc after start", crcw[0], 32'hFFFF);
    modbus(8'h02, 1'b0);

    // Abort on the fourth shift cycle.
    send(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), a);
    repeat (3) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(rdy[0]), 32'd1);
    chk("abort busy", 32'(bsy[0]), 32'd0);
    chk("abort crc", crcw[0], 32'hFFFF);
    repeat (12) @(negedge clk);

    // Reset mid-shift.
    send(0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), a);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst crc", crcw[0], 32'hFFFF);
    chk("rst ready", 32'(rdy[0]), 32'd1);
    chk("rst busy", 32'(bsy[0]), 32'd0);
    chk("rst done", 32'(dn[0]), 32'd0);
    repeat (12) @(negedge clk);

    // vi held across the whole shift is accepted only once.
    send(0, 8'h31, 1'b0, 1'b1, 1'b1, 1'b1, mk(1, 32'h947E, 0, 0), a);
    repeat (8) @(posedge clk);
    #1 vi[0] = 1'b0;
    drain(0);
    repeat (12) @(negedge clk);

    // start with vi mid-frame restarts from INIT.
    send(0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0), a);
    send(0, 8'h32, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0), a);
    send(0, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, mk(1, 32'h947E, 0, 0), a);
    drain(0);

    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("dut%0d leftover expectations", k), 32'(q[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_unit.md
# crc_unit

Parametrised, handshaked CRC engine that folds a stream of DATA_W-bit words into a CRC_W-bit running checksum, processing BITS_PER_CLK bits per clock. It replaces the fixed Modbus CRC-16 byte engine and sits between the RTU frame receiver/transmitter and the frame checker. It adds frame start/last marking, a valid/ready handshake, configurable polynomial, bit order and final XOR, and a residue check that raises a match flag on a correct frame.

## Interface
- CRC_W, 16, CRC width; 8..32.
- POLY, 16'hA001, polynomial; reflected form when REFLECT=1, normal form when REFLECT=0.
- INIT, 16'hFFFF, register value loaded by rst and start.
- XOROUT, 16'h0000, XOR applied to the crc output only.
- REFLECT, 1, 1 = LSB-first (shift right), 0 = MSB-first (shift left).
- DATA_W, 8, input word width.
- BITS_PER_CLK, 1, bits folded per shift cycle; must divide DATA_W.
- RESIDUE, 16'h0000, register value that indicates a good frame when CRC bytes are included.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new frame: register reloads INIT.
- vi  in  1  input word valid.
- ready  out  1  engine can accept a word.
- di  in  DATA_W  input word.
- last  in  1  qualifies di as the frame's final word; sampled with vi.
- crc  out  CRC_W  register ^ XOROUT.
- done  out  1  one-cycle pulse: word fully folded, crc valid.
- match  out  1  after the last word, register == RESIDUE; held until start or rst.
- busy  out  1  shift in progress.

## Operation
- States: IDLE, SHIFT. ready = (state==IDLE); busy = (state==SHIFT).
- Accept = vi && ready. On accept: REFLECT=1 loads reg ^ di (zero-extended); REFLECT=0 loads reg ^ (di << (CRC_W-DATA_W)); latch last; cnt=0; go to SHIFT.
- SHIFT: each cycle applies BITS_PER_CLK unrolled steps. Reflected step: reg = (reg>>1) ^ (reg[0] ? POLY : 0). Normal step: reg = (reg<<1) ^ (reg[CRC_W-1] ? POLY : 0), truncated to CRC_W.
- After N = DATA_W/BITS_PER_CLK cycles, return to IDLE and assert done for one cycle. If last was latched, match <= (new reg == RESIDUE).
- Parameter check at elaboration: fatal if DATA_W % BITS_PER_CLK != 0, or if REFLECT=0 and CRC_W < DATA_W.
- start in IDLE reloads INIT and clears match. If vi is also high, the word is accepted and folded into INIT.
- start in SHIFT aborts the word: register = INIT, state = IDLE, match = 0, done stays 0; vi is ignored in that cycle.
- vi while busy is not accepted. The source holds di/last/vi until ready (standard valid/ready).
- Without start, consecutive frames chain from the current register value.

## Timing
- Reset values: crc = INIT^XOROUT, ready=1, busy=0, done=0, match=0; state IDLE; cnt=0.
- rst mid-SHIFT: the next cycle is the reset state; no done is issued.
- Accept at edge 0, shifts at edges 1..N. done, ready and the final crc are visible after edge N. match is updated at the same edge.
- Minimum word period N+1 cycles. With vi held high, the next accept is at edge N+1.
- Defaults: N=8, so 9 cycles per byte. BITS_PER_CLK=DATA_W gives N=1, 2 cycles per word.
- crc is combinational from the register and changes during SHIFT. It is valid only while done is high or in IDLE.

## Structure
- Shared types package: crc_state_t enum {CRC_IDLE_S, CRC_SHIFT_S}, and the Modbus constant defaults (poly A001, init FFFF).
- Sub-module crc_step: combinational, parametrised on CRC_W/POLY/REFLECT/BITS_PER_CLK; maps reg to reg after BITS_PER_CLK steps. The top holds the FSM, counter, handshake and flags.

## Test plan
- Defaults; start with ASCII "123456789" (0x31..0x39), last on 0x39 → done after each byte at 8 cycles after accept; final crc=0x4B37.
- Defaults; frame 01 03 00 00 00 01 → crc=0x0A84. Then 84, 0A with last → match=1. Repeat with 03 corrupted to 02 → match=0.
- BITS_PER_CLK=8, same "123456789" → crc=0x4B37; done 1 cycle after each accept; vi held gives 2-cycle period.
- CRC_W=32, POLY=32'hEDB88320, INIT=XOROUT=32'hFFFFFFFF → "123456789" gives 0xCBF43926. REFLECT=0, POLY=16'h1021, INIT=16'hFFFF → 0x29B1.
- Abort and reset: start at SHIFT cycle 4 → no done, ready next cycle, crc=INIT. rst at cycle 3 → reset values. vi held while busy → accepted exactly once.
- start+vi same cycle mid-frame with di=0x31 → register equals the single-byte CRC of 0x31 from INIT. match clears on start.
